wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Final (write-back) stage of the 5-stage MIPS pipeline, directly downstream of the memory stage.
//  Retires one instruction per cycle:
//   - writes the GPR file and drives forwarding/dependence info;
//   - hosts the CP0 subset: BadVAddr, Count, Compare, Status, Cause, EPC;
//   - commits exceptions, interrupts and ERET, and issues the pipeline flush and redirect PC.
// PARAMETERS
//  EX_ENTRY   32'hbfc00380  redirect PC on exception/interrupt
//  COUNT_DIV  2             Count increments once every COUNT_DIV cycles (>=1)
// PORTS
//  clk             in   1    clock
//  reset           in   1    synchronous, active-high
//  ws_allowin      out  1    stage can accept from memory stage
//  ms_to_ws_valid  in   1    memory stage has a valid instruction
//  ms_to_ws_bus    in   120  {mfc0[119], mtc0[118], cp0_addr[117:110] = {rd,sel},
//                            pc_error[109], badvaddr[108:77], ex_code[76:72], eret[71], bd[70],
//                            gr_we[69], dest[68:64], result[63:32], pc[31:0]}
//  ext_int         in   6    hardware interrupt lines, level-sensitive
//  rf_we           out  1    GPR write enable
//  rf_waddr        out  5    GPR write address
//  rf_wdata        out  32   GPR write data
//  WB_dest         out  5    dest of valid WB instruction, 0 when invalid (dependence check)
//  WB_dest_data    out  32   rf_wdata gated by ws_valid (forwarding)
//  WS_EX           out  1    exception/interrupt committing this cycle (flushes earlier stages)
//  ERET            out  1    ERET committing this cycle (flushes earlier stages)
//  flush_pc        out  32   EX_ENTRY when WS_EX, EPC when ERET, else 0
//  debug_wb_pc     out  32   pc of WB instruction
// BEHAVIOUR
//  Handshake:
//   - ws_ready_go = 1; ws_allowin = !ws_valid || ws_ready_go.
//   - ws_valid <= ms_to_ws_valid when ws_allowin; cleared on reset, WS_EX or ERET.
//   - Bus register loads on ms_to_ws_valid && ws_allowin. Latency: 1 cycle into WB, commit same cycle.
//  Interrupt:
//   - int_req = Status.IE && !Status.EXL && |(Cause.IP & Status.IM).
//   - Cause.IP[7:2] = {ext_int[5] | Cause.TI, ext_int[4:0]}, resampled every cycle; IP[1:0] are software bits (MTC0).
//  Exception commit:
//   - Taken = ws_valid && (ex_code != 0 || int_req); interrupt takes priority over ex_code, with ExcCode = 0.
//   - Effects: WS_EX = 1; rf_we = 0.
//   - If EXL was 0: EPC <= bd ? pc-4 : pc; Cause.BD <= bd. If EXL was already 1, EPC and BD are unchanged.
//   - Status.EXL <= 1; Cause.ExcCode <= code.
//   - BadVAddr <= badvaddr when code = 4 (AdEL) or 5 (AdES). pc_error selects pc as badvaddr upstream.
//  ERET:
//   - ws_valid && eret && no exception: ERET = 1; Status.EXL <= 0; flush_pc = EPC.
//  MTC0 (ws_valid, no exception):
//   - Writes the addressed reg; rf_we = 0.
//   - Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC; Count; Compare.
//   - BadVAddr and Status.BEV (bit 22, fixed 1) are read-only.
//   - Writing Compare clears Cause.TI.
//  MFC0:
//   - rf_wdata = CP0 read (unimplemented addresses read 0); rf_we = gr_we.
//  GPR write:
//   - rf_we = ws_valid && gr_we && !WS_EX. rf_waddr = dest.
//   - rf_wdata = mfc0 ? cp0_rdata : result.
//  Count/Compare:
//   - Divider counter wraps at COUNT_DIV-1 and increments Count; Count wraps 32'hffffffff -> 0.
//   - MTC0 Count in the same cycle as an increment: written value wins, divider resets.
//   - Count == Compare (post-update) sets Cause.TI; TI stays set until Compare is written.
//  Write priority, same cycle: exception > ERET > MTC0.
//  Reset values:
//   - Status = 32'h0040_0000; Cause, EPC, BadVAddr, Count, Compare = 0; divider = 0.
//   - All outputs 0 except ws_allowin = 1.
//  Reset mid-operation discards the WB instruction without committing it.
// TESTING
//  - ADDU dest 5, result 32'h1234 -> one cycle later rf_we=1, rf_waddr=5, WB_dest=5, WB_dest_data=32'h1234.
//  - ex_code=5'h0c, bd=1, pc=32'hbfc00100 -> WS_EX=1, flush_pc=32'hbfc00380, EPC=32'hbfc000fc, Cause=32'h8000_0030, rf_we=0.
//  - Load with ex_code=4, badvaddr=32'h1001 -> BadVAddr=32'h1001, ExcCode=4. Then ERET -> ERET=1, flush_pc=EPC, EXL=0.
//  - MTC0 Compare=10, Count=0, Status=32'h8001 -> TI after 20 cycles (COUNT_DIV=2); next valid instruction takes interrupt with ExcCode=0.
//  - Exception while EXL=1 -> EPC unchanged. Simultaneous MTC0 Count and increment -> Count = written value.
//  - Reset asserted with valid ERET in WB -> no flush; Status=32'h0040_0000.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back stage of the 5-stage MIPS pipeline. Retires one
//            instruction per cycle, writes the GPR file, hosts the CP0
//            subset (BadVAddr, Count, Compare, Status, Cause, EPC) and
//            commits exceptions, interrupts and ERET with flush/redirect.
// Ports    : clk, reset (sync, active-high)
//            ws_allowin / ms_to_ws_valid / ms_to_ws_bus : memory-stage handshake
//            ext_int        : level-sensitive hardware interrupt lines
//            rf_we/waddr/wdata : GPR write port
//            WB_dest, WB_dest_data : dependence check / forwarding
//            WS_EX, ERET, flush_pc : pipeline flush and redirect
//            debug_wb_pc    : pc of the instruction in WB
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
    parameter int          COUNT_DIV = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic         ws_allowin,
    input  logic         ms_to_ws_valid,
    input  logic [119:0] ms_to_ws_bus,
    input  logic [5:0]   ext_int,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [31:0]  rf_wdata,
    output logic [4:0]   WB_dest,
    output logic [31:0]  WB_dest_data,
    output logic         WS_EX,
    output logic         ERET,
    output logic [31:0]  flush_pc,
    output logic [31:0]  debug_wb_pc
);

    localparam int                 c_DIV_W      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(COUNT_DIV - 1);
    // CP0 addresses encoded as {rd, sel}
    localparam logic [7:0]         c_ADDR_BADV  = {5'd8,  3'd0};
    localparam logic [7:0]         c_ADDR_COUNT = {5'd9,  3'd0};
    localparam logic [7:0]         c_ADDR_CMP   = {5'd11, 3'd0};
    localparam logic [7:0]         c_ADDR_STAT  = {5'd12, 3'd0};
    localparam logic [7:0]         c_ADDR_CAUSE = {5'd13, 3'd0};
    localparam logic [7:0]         c_ADDR_EPC   = {5'd14, 3'd0};

    logic                r_ws_valid;
    logic [119:0]        r_bus;

    logic [31:0]         r_badvaddr;
    logic [31:0]         r_count;
    logic [31:0]         r_compare;
    logic [31:0]         r_epc;
    logic [c_DIV_W-1:0]  r_div;
    logic [7:0]          r_status_im;
    logic                r_status_exl;
    logic                r_status_ie;
    logic                r_cause_bd;
    logic                r_cause_ti;
    logic [7:2]          r_cause_ip_hw;
    logic [1:0]          r_cause_ip_sw;
    logic [4:0]          r_cause_exc;

    // Bus fields
    logic                w_bus_mfc0;
    logic                w_bus_mtc0;
    logic [7:0]          w_cp0_addr;
    logic [31:0]         w_bus_badv;
    logic [4:0]          w_bus_exc;
    logic                w_bus_eret;
    logic                w_bus_bd;
    logic                w_bus_gr_we;
    logic [4:0]          w_bus_dest;
    logic [31:0]         w_bus_result;
    logic [31:0]         w_bus_pc;
    logic                w_unused_bits;

    assign w_bus_mfc0    = r_bus[119];
    assign w_bus_mtc0    = r_bus[118];
    assign w_cp0_addr    = r_bus[117:110];
    assign w_unused_bits = r_bus[109];   // pc_error: already folded into badvaddr upstream
    assign w_bus_badv    = r_bus[108:77];
    assign w_bus_exc     = r_bus[76:72];
    assign w_bus_eret    = r_bus[71];
    assign w_bus_bd      = r_bus[70];
    assign w_bus_gr_we   = r_bus[69];
    assign w_bus_dest    = r_bus[68:64];
    assign w_bus_result  = r_bus[63:32];
    assign w_bus_pc      = r_bus[31:0];

    logic                w_valid;
    logic [7:0]          w_cause_ip;
    logic                w_int_req;
    logic                w_ex_taken;
    logic [4:0]          w_exc_code;
    logic                w_eret;
    logic                w_mtc0;
    logic                w_mtc0_count;
    logic                w_mtc0_cmp;
    logic                w_div_tick;
    logic [31:0]         w_status;
    logic [31:0]         w_cause;
    logic [31:0]         w_cp0_rdata;

    // Synchronous reset must suppress the commit of whatever sits in WB
    // during the reset cycle itself.
    assign w_valid      = r_ws_valid && !reset;
    assign w_cause_ip   = {r_cause_ip_hw, r_cause_ip_sw};
    assign w_int_req    = r_status_ie && !r_status_exl && (|(w_cause_ip & r_status_im));
    assign w_ex_taken   = w_valid && ((w_bus_exc != 5'd0) || w_int_req);
    assign w_exc_code   = w_int_req ? 5'd0 : w_bus_exc;
    assign w_eret       = w_valid && w_bus_eret && !w_ex_taken;
    assign w_mtc0       = w_valid && w_bus_mtc0 && !w_ex_taken;
    assign w_mtc0_count = w_mtc0 && (w_cp0_addr == c_ADDR_COUNT);
    assign w_mtc0_cmp   = w_mtc0 && (w_cp0_addr == c_ADDR_CMP);
    assign w_div_tick   = (r_div == c_DIV_LAST);

    assign w_status = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, r_cause_ti, 14'd0, w_cause_ip, 1'b0, r_cause_exc, 2'b00};

    always_comb begin
        w_cp0_rdata = 32'd0;
        case (w_cp0_addr)
            c_ADDR_BADV:  w_cp0_rdata = r_badvaddr;
            c_ADDR_COUNT: w_cp0_rdata = r_count;
            c_ADDR_CMP:   w_cp0_rdata = r_compare;
            c_ADDR_STAT:  w_cp0_rdata = w_status;
            c_ADDR_CAUSE: w_cp0_rdata = w_cause;
            c_ADDR_EPC:   w_cp0_rdata = r_epc;
            default:      w_cp0_rdata = 32'd0;
        endcase
    end

    // Handshake: WB always completes in one cycle
    assign ws_allowin = !r_ws_valid || 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
        end else if (w_ex_taken || w_eret) begin
            r_ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            r_bus <= ms_to_ws_bus;
        end
    end

    // CP0 state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_badvaddr    <= 32'd0;
            r_count       <= 32'd0;
            r_compare     <= 32'd0;
            r_epc         <= 32'd0;
            r_div         <= '0;
            r_status_im   <= 8'd0;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_bd    <= 1'b0;
            r_cause_ti    <= 1'b0;
            r_cause_ip_hw <= 6'd0;
            r_cause_ip_sw <= 2'd0;
            r_cause_exc   <= 5'd0;
        end else begin
            // Timer interrupt shares IP7 with ext_int[5]
            r_cause_ip_hw <= {ext_int[5] | r_cause_ti, ext_int[4:0]};

            // A software write to Count overrides a coincident increment
            if (w_mtc0_count) begin
                r_count <= w_bus_result;
                r_div   <= '0;
            end else if (w_div_tick) begin
                r_count <= r_count + 32'd1;
                r_div   <= '0;
            end else begin
                r_div   <= r_div + 1'b1;
            end

            // TI is raised only when an increment lands on Compare, so the
            // post-reset Count == Compare == 0 state does not fire it.
            if (w_mtc0_cmp) begin
                r_cause_ti <= 1'b0;
            end else if (w_div_tick && !w_mtc0_count && ((r_count + 32'd1) == r_compare)) begin
                r_cause_ti <= 1'b1;
            end

            if (w_ex_taken) begin
                if (!r_status_exl) begin
                    r_epc      <= w_bus_bd ? (w_bus_pc - 32'd4) : w_bus_pc;
                    r_cause_bd <= w_bus_bd;
                end
                r_status_exl <= 1'b1;
                r_cause_exc  <= w_exc_code;
                if ((w_exc_code == 5'd4) || (w_exc_code == 5'd5)) begin
                    r_badvaddr <= w_bus_badv;
                end
            end else if (w_eret) begin
                r_status_exl <= 1'b0;
            end else if (w_mtc0) begin
                case (w_cp0_addr)
                    c_ADDR_CMP:   r_compare <= w_bus_result;
                    c_ADDR_STAT: begin
                        r_status_im  <= w_bus_result[15:8];
                        r_status_exl <= w_bus_result[1];
                        r_status_ie  <= w_bus_result[0];
                    end
                    c_ADDR_CAUSE: r_cause_ip_sw <= w_bus_result[9:8];
                    c_ADDR_EPC:   r_epc <= w_bus_result;
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    assign rf_we        = w_valid && w_bus_gr_we && !w_ex_taken;
    assign rf_waddr     = w_bus_dest;
    assign rf_wdata     = w_bus_mfc0 ? w_cp0_rdata : w_bus_result;
    assign WB_dest      = w_valid ? w_bus_dest : 5'd0;
    assign WB_dest_data = w_valid ? rf_wdata : 32'd0;
    assign WS_EX        = w_ex_taken;
    assign ERET         = w_eret;
    assign flush_pc     = w_ex_taken ? EX_ENTRY : (w_eret ? r_epc : 32'd0);
    assign debug_wb_pc  = w_bus_pc;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage. Instructions are
//            issued one at a time; CP0 state is observed through MFC0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [119:0] ms_to_ws_bus;
    logic [5:0]   ext_int;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [4:0]   WB_dest;
    logic [31:0]  WB_dest_data;
    logic         WS_EX;
    logic         ERET;
    logic [31:0]  flush_pc;
    logic [31:0]  debug_wb_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] A_BADV  = 8'h40;
    localparam logic [7:0] A_COUNT = 8'h48;
    localparam logic [7:0] A_CMP   = 8'h58;
    localparam logic [7:0] A_STAT  = 8'h60;
    localparam logic [7:0] A_CAUSE = 8'h68;
    localparam logic [7:0] A_EPC   = 8'h70;

    wb_stage #(
        .EX_ENTRY  (32'hbfc00380),
        .COUNT_DIV (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
        .ext_int        (ext_int),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .WB_dest        (WB_dest),
        .WB_dest_data   (WB_dest_data),
        .WS_EX          (WS_EX),
        .ERET           (ERET),
        .flush_pc       (flush_pc),
        .debug_wb_pc    (debug_wb_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [119:0] mk(
        input logic        mfc0,
        input logic        mtc0,
        input logic [7:0]  addr,
        input logic [31:0] badv,
        input logic [4:0]  exc,
        input logic        eret,
        input logic        bd,
        input logic        gr_we,
        input logic [4:0]  dest,
        input logic [31:0] result,
        input logic [31:0] pc
    );
        return {mfc0, mtc0, addr, 1'b0, badv, exc, eret, bd, gr_we, dest, result, pc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction; on return it is in WB and its commit
    // outputs are settled.
    task automatic send(input logic [119:0] b);
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = b;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
        send(mk(1'b0, 1'b1, addr, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, data, 32'hbfc00800));
    endtask

    task automatic mfc0_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        send(mk(1'b1, 1'b0, addr, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hdeadbeef, 32'hbfc00900));
        chk(tag, rf_wdata, exp);
    endtask

    initial begin
        reset          = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus   = '0;
        ext_int        = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_allowin", {31'd0, ws_allowin}, 32'd1);
        chk("rst_rf_we",   {31'd0, rf_we},      32'd0);
        chk("rst_ws_ex",   {31'd0, WS_EX},      32'd0);
        chk("rst_eret",    {31'd0, ERET},       32'd0);
        chk("rst_flushpc", flush_pc,            32'd0);
        chk("rst_wbdest",  {27'd0, WB_dest},    32'd0);
        chk("rst_dbgpc",   debug_wb_pc,         32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Plain ALU write-back
        send(mk(1'b0, 1'b0, 8'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'hbfc00000));
        chk("addu_rf_we",    {31'd0, rf_we},   32'd1);
        chk("addu_waddr",    {27'd0, rf_waddr}, 32'd5);
        chk("addu_wdata",    rf_wdata,          32'h1234);
        chk("addu_wbdest",   {27'd0, WB_dest},  32'd5);
        chk("addu_wbdata",   WB_dest_data,      32'h1234);
        chk("addu_dbgpc",    debug_wb_pc,       32'hbfc00000);
        chk("addu_no_ex",    {31'd0, WS_EX},    32'd0);
        @(posedge clk);
        #1;
        chk("bubble_wbdest", {27'd0, WB_dest},  32'd0);
        chk("bubble_rf_we",  {31'd0, rf_we},    32'd0);

        // Overflow-class exception in a delay slot
        send(mk(1'b0, 1'b0, 8'd0, 32'd0, 5'h0c, 1'b0, 1'b1, 1'b1, 5'd3, 32'h55, 32'hbfc00100));
        chk("ex_ws_ex",    {31'd0, WS_EX}, 32'd1);
        chk("ex_flushpc",  flush_pc,       32'hbfc00380);
        chk("ex_rf_we",    {31'd0, rf_we}, 32'd0);
        mfc0_chk("ex_epc",   A_EPC,   32'hbfc000fc);
        mfc0_chk("ex_cause", A_CAUSE, 32'h8000_0030);

        // AdEL while EXL already set: EPC and BD hold, BadVAddr captured
        send(mk(1'b0, 1'b0, 8'd0, 32'h1001, 5'd4, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'hbfc00200));
        chk("adel_ws_ex", {31'd0, WS_EX}, 32'd1);
        mfc0_chk("adel_epc",   A_EPC,   32'hbfc000fc);
        mfc0_chk("adel_cause", A_CAUSE, 32'h8000_0010);
        mfc0_chk("adel_badv",  A_BADV,  32'h1001);

        // ERET
        send(mk(1'b0, 1'b0, 8'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'hbfc00300));
        chk("eret_out",     {31'd0, ERET},  32'd1);
        chk("eret_flushpc", flush_pc,       32'hbfc000fc);
        chk("eret_no_ex",   {31'd0, WS_EX}, 32'd0);
        mfc0_chk("eret_status", A_STAT, 32'h0040_0000);

        // MTC0 writable fields and read-only registers
        mtc0(A_EPC, 32'h1234_5678);
        mfc0_chk("mtc0_epc", A_EPC, 32'h1234_5678);
        mtc0(A_BADV, 32'hffff_ffff);
        mfc0_chk("mtc0_badv_ro", A_BADV, 32'h1001);
        mtc0(A_STAT, 32'hffff_ffff);
        mfc0_chk("mtc0_status", A_STAT, 32'h0040_ff03);
        mtc0(A_STAT, 32'h0000_0000);
        mtc0(A_CAUSE, 32'hffff_ffff);
        mfc0_chk("mtc0_cause", A_CAUSE, 32'h8000_0310);

        // Count: second write lands on a divider tick and must win
        mtc0(A_COUNT, 32'h100);
        mfc0_chk("count_w1",   A_COUNT, 32'h100);
        mtc0(A_COUNT, 32'h200);
        mfc0_chk("count_w2",   A_COUNT, 32'h200);
        mfc0_chk("count_hold", A_COUNT, 32'h200);
        mfc0_chk("count_inc",  A_COUNT, 32'h201);

        // Timer interrupt
        mtc0(A_CAUSE, 32'd0);
        mtc0(A_CMP,   32'd10);
        mtc0(A_COUNT, 32'd0);
        mtc0(A_STAT,  32'h0000_8001);
        send(mk(1'b0, 1'b0, 8'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'hbfc00380));
        chk("timer_early_no_int", {31'd0, WS_EX}, 32'd0);
        repeat (30) @(posedge clk);
        send(mk(1'b0, 1'b0, 8'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h77, 32'hbfc00400));
        chk("int_ws_ex",    {31'd0, WS_EX}, 32'd1);
        chk("int_flushpc",  flush_pc,       32'hbfc00380);
        chk("int_rf_we",    {31'd0, rf_we}, 32'd0);
        mfc0_chk("int_cause", A_CAUSE, 32'h4000_8000);
        mfc0_chk("int_epc",   A_EPC,   32'hbfc00400);
        mtc0(A_CMP, 32'd0);

        // Reset arriving while an ERET sits in WB
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(1'b0, 1'b0, 8'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'hbfc00500);
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
        reset          = 1'b1;
        #1;
        chk("rsteret_eret",    {31'd0, ERET},  32'd0);
        chk("rsteret_flushpc", flush_pc,       32'd0);
        chk("rsteret_ws_ex",   {31'd0, WS_EX}, 32'd0);
        @(posedge clk);
        #1;
        chk("rsteret_dbgpc", debug_wb_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mfc0_chk("rsteret_status", A_STAT, 32'h0040_0000);
        mfc0_chk("rsteret_epc",    A_EPC,  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
